aes_inv_key_sched: RTL and testbench
====================================

Name: aes_inv_key_sched

Overview:
- Iterative AES-128 decryption key source.
- Accepts the cipher key, runs the forward expansion internally to reach the round-10 key, then emits round keys 10 down to 0 in order over a valid/ready stream.
- Sits between the key load path and the inverse-cipher round datapath. It replaces storage of all 11 round keys with one 128-bit register walked backwards.

Parameters:
- NR, 10, number of AES rounds (AES-128 only; other values are unsupported).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- key_in  in  128  cipher key, word w0 in [127:96]; sampled on the accepted start cycle
- rk_ready  in  1  consumer accepts rk_out this cycle
- busy  out  1  high in every state except IDLE
- rk_valid  out  1  rk_out/rk_idx hold a valid round key
- rk_out  out  128  current round key, word 0 in [127:96]
- rk_idx  out  4  round number of rk_out: 10 down to 0
- done  out  1  one-cycle pulse after round key 0 is accepted

Behaviour:
- Reset (async, any state): state=IDLE; key_reg=0, rcon_reg=0, idx=0; busy=0, rk_valid=0, done=0.
  - rk_out mirrors key_reg and reads 0. rk_idx mirrors idx and reads 0.
  - An operation in flight is abandoned with no partial output.
- States: IDLE, EXPAND, EMIT, FIN.
- IDLE:
  - On start=1: key_reg<=key_in, rcon_reg<=0x01, idx<=0, go to EXPAND.
  - start=0: stay in IDLE.
- EXPAND (forward step, one round per cycle):
  - t = SubWord(RotWord(w3)) ^ {rcon_reg,24'h0}.
  - Next words: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - rcon_reg<=xtime(rcon_reg); idx<=idx+1.
  - When the idx=9 step completes: idx=10, key_reg holds the round-10 key, rcon_reg holds 0x36. Go to EMIT.
  - EXPAND lasts exactly 10 cycles.
- EMIT:
  - rk_valid=1, rk_out=key_reg, rk_idx=idx.
  - First rk_valid occurs 11 cycles after the start edge.
  - rk_valid=1 with rk_ready=0: rk_out and rk_idx hold stable indefinitely.
  - On handshake (rk_valid & rk_ready) with idx>0, inverse step:
    - w3p=w3^w2, w2p=w2^w1, w1p=w1^w0.
    - w0p = w0 ^ SubWord(RotWord(w3p)) ^ {rcon_reg,24'h0}.
    - rcon_reg<=inv_xtime(rcon_reg); idx<=idx-1.
  - Next key is valid on the following cycle. With rk_ready held high, one key is emitted per cycle (11 consecutive cycles).
  - On handshake with idx=0: go to FIN. key_reg is unchanged.
- FIN:
  - done=1 for one cycle, rk_valid=0, busy=1. Next state IDLE.
- Arithmetic rules:
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 0x1b : 0).
  - inv_xtime(x) = x[0] ? ({1'b0,(x^0x1b)[7:1]} | 0x80) : x>>1.
  - This yields the sequence 0x36, 0x1b, 0x80, ..., 0x01.
- S-box sharing: a single 32-bit SubWord path (4 byte S-boxes).
  - Input mux selects RotWord(w3) in EXPAND and RotWord(w3p) in EMIT.
  - Only one step occurs per cycle, so there is no conflict.
- Other boundary rules:
  - start outside IDLE is ignored, including in FIN.
  - rk_ready outside EMIT is ignored.
  - A key_in change after acceptance has no effect.

Decomposition:
- Shared package aes_pkg:
  - AES_NR=10, RCON_FIRST=8'h01, RCON_LAST=8'h36.
  - State enum type for IDLE/EXPAND/EMIT/FIN.
  - xtime and inv_xtime functions.
- Sub-module: the existing byte S_Box, instantiated 4 times as the shared SubWord. No new sub-module is needed.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> sequence:
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - idx9 = ac7766f319fadc2128d12941575c006e
  - idx1 = a0fafe1788542cb123a339392a6c7605
  - idx0 = the input key
  - 11 consecutive valid cycles, then done one cycle after idx0 is accepted.
- All-zero key -> idx10 = b4ef5bcb3e92e21123e951cf6f8f188e, idx0 = 0. First valid exactly 11 cycles after start.
- Random rk_ready backpressure on the A.1 key -> same 11 keys in the same order. rk_out/rk_idx stable on every cycle with valid=1 and ready=0; no key skipped or repeated.
- start pulses during EXPAND, EMIT and FIN with a different key_in -> ignored; output still matches the first key.
- rst asserted mid-EXPAND (cycle 5) and mid-EMIT (idx 6):
  - Asynchronous: all outputs 0 immediately, without waiting for a clock edge.
  - A fresh start afterwards yields the full correct sequence.
- rk_ready held low at idx0 for 5 cycles -> done stays 0. When ready rises, done pulses one cycle later, then busy=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES helpers: round constants, key-schedule FSM states and GF(2^8) arithmetic.
package aes_pkg;

  localparam int unsigned AES_NR     = 10;
  localparam logic [7:0]  RCON_FIRST = 8'h01;
  localparam logic [7:0]  RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    StIdle,
    StExpand,
    StEmit,
    StFin
  } ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Exact inverse of xtime: walks the round constant backwards.
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] y;
    y = x ^ 8'h1b;
    return x[0] ? ({1'b0, y[7:1]} | 8'h80) : {1'b0, x[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gf_mul(gf_mul(x, x), x);
    x7   = gf_mul(gf_mul(x3, x3), x);
    x15  = gf_mul(gf_mul(x7, x7), x);
    x31  = gf_mul(gf_mul(x15, x15), x);
    x63  = gf_mul(gf_mul(x31, x31), x);
    x127 = gf_mul(gf_mul(x63, x63), x);
    return gf_mul(x127, x127);
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_inv_key_sched_sbox.sv
// Forward AES byte S-box: GF(2^8) inverse followed by the affine transform.
module aes_inv_key_sched_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = sbox_affine(gf_inv(din));

endmodule

// File: rtl/aes_inv_key_sched.sv
// Iterative AES-128 decryption key source: expands forward to the last round key,
// then walks a single 128-bit register backwards, emitting round keys NR..0.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  localparam logic [3:0] LastIdx = 4'(NR);

  ks_state_e    state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   idx_q, idx_d;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] w1p, w2p, w3p;
  logic [31:0] sub_in, sub_out, t;
  logic [31:0] f0, f1, f2, f3;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // Previous-round words recovered from the current key.
  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // Shared SubWord: RotWord(w3) going forward, RotWord(w3p) going backward.
  assign sub_in = (state_q == StEmit) ? {w3p[23:0], w3p[31:24]} : {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_inv_key_sched_sbox u_sbox (
      .din  (sub_in[8*b +: 8]),
      .dout (sub_out[8*b +: 8])
    );
  end

  assign t = sub_out ^ {rcon_q, 24'h000000};

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  // Next-state logic for the FSM, key register, round constant and index.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          key_d   = key_in;
          rcon_d  = RCON_FIRST;
          idx_d   = 4'd0;
          state_d = StExpand;
        end
      end
      StExpand: begin
        key_d = {f0, f1, f2, f3};
        idx_d = idx_q + 4'd1;
        // The last step keeps rcon at RCON_LAST so the backward walk starts from it.
        if (idx_q == LastIdx - 4'd1) begin
          state_d = StEmit;
        end else begin
          rcon_d = xtime(rcon_q);
        end
      end
      StEmit: begin
        if (rk_ready) begin
          if (idx_q != 4'd0) begin
            key_d  = {w0 ^ t, w1p, w2p, w3p};
            rcon_d = inv_xtime(rcon_q);
            idx_d  = idx_q - 4'd1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= '0;
      rcon_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign rk_valid = (state_q == StEmit);
  assign done     = (state_q == StFin);
  assign rk_out   = key_q;
  assign rk_idx   = idx_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched: known-answer round keys, timing, backpressure,
// ignored start pulses, asynchronous reset and done handshake.
module tb_aes_inv_key_sched;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO = 128'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic [127:0] rk;
  } vec_t;

  vec_t vecs [13];
  int   errors = 0;
  int   checks = 0;
  bit   noise  = 1'b0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance one clock; observe/drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (noise) begin
      start  = 1'($urandom_range(0, 1));
      key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  function automatic bit lookup(input logic [127:0] key, input logic [3:0] idx,
                                output logic [127:0] rk);
    rk = '0;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].key == key && vecs[i].idx == idx) begin
        rk = vecs[i].rk;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rk_out"}, rk_out, 0);
    chk({tag, "_rk_idx"}, rk_idx, 0);
  endtask

  // Start presented in cycle 0; the first valid key must show in cycle 11.
  task automatic start_op(input logic [127:0] key);
    int cyc;
    start  = 1'b1;
    key_in = key;
    tick();
    start  = 1'b0;
    key_in = ~key;
    cyc    = 1;
    chk("busy_in_expand", busy, 1);
    while (!rk_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("first_valid_cycle", 128'(cyc), 128'(11));
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready held low 5 cycles at idx 0.
  task automatic collect(input logic [127:0] key, input int mode);
    int           exp_idx = 10;
    int           stall   = 0;
    int           cyc     = 0;
    logic [127:0] exp_rk;
    while (exp_idx >= 0 && cyc < 300) begin
      case (mode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = 1'($urandom_range(0, 1));
        default: rk_ready = (exp_idx == 0 && stall < 5) ? 1'b0 : 1'b1;
      endcase
      if (!rk_valid) begin
        chk("rk_valid_in_emit", rk_valid, 1);
        return;
      end
      chk("rk_idx", rk_idx, 128'(exp_idx));
      if (lookup(key, 4'(exp_idx), exp_rk)) chk($sformatf("rk_out_idx%0d", exp_idx), rk_out, exp_rk);
      if (exp_idx == 0 && !rk_ready) begin
        stall++;
        chk("done_while_stalled", done, 0);
      end
      if (rk_ready) exp_idx--;
      tick();
      cyc++;
    end
    if (exp_idx >= 0) begin
      chk("collect_timeout", 128'(exp_idx), 128'(-1));
      return;
    end
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 1);
    chk("fin_rk_valid", rk_valid, 0);
    if (noise) begin
      start  = 1'b1;
      key_in = KEY_ZERO;
    end
    noise = 1'b0;
    tick();
    start = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_rk_valid", rk_valid, 0);
  endtask

  // Assert reset between clock edges and check outputs before the next edge.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 check_zero(tag);
    #2 rst = 1'b0;
    tick();
    check_zero({tag, "_after"});
  endtask

  initial begin
    vecs[0]  = '{KEY_A1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1]  = '{KEY_A1, 4'd9,  128'hac7766f319fadc2128d12941575c006e};
    vecs[2]  = '{KEY_A1, 4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    vecs[3]  = '{KEY_A1, 4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[4]  = '{KEY_A1, 4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[5]  = '{KEY_A1, 4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{KEY_A1, 4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[7]  = '{KEY_A1, 4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[8]  = '{KEY_A1, 4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    vecs[9]  = '{KEY_A1, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[10] = '{KEY_A1, 4'd0,  KEY_A1};
    vecs[11] = '{KEY_ZERO, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[12] = '{KEY_ZERO, 4'd0,  KEY_ZERO};

    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    rk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    tick();

    // Known-answer runs with free-flowing ready.
    start_op(KEY_A1);
    collect(KEY_A1, 0);
    start_op(KEY_ZERO);
    collect(KEY_ZERO, 0);

    // Random backpressure.
    start_op(KEY_A1);
    collect(KEY_A1, 1);

    // Stray start pulses with other keys in EXPAND, EMIT and FIN.
    noise = 1'b1;
    start_op(KEY_A1);
    collect(KEY_A1, 0);

    // Ready held low at idx 0.
    rk_ready = 1'b0;
    start_op(KEY_A1);
    collect(KEY_A1, 2);

    // Reset in the middle of expansion (cycle 5).
    start    = 1'b1;
    key_in   = KEY_A1;
    tick();
    start    = 1'b0;
    repeat (4) tick();
    chk("mid_expand_busy", busy, 1);
    async_reset("rst_expand");
    start_op(KEY_A1);
    collect(KEY_A1, 0);

    // Reset while emitting idx 6.
    start_op(KEY_A1);
    rk_ready = 1'b1;
    for (int i = 0; i < 20 && !(rk_valid && rk_idx == 4'd6); i++) tick();
    chk("reached_idx6", rk_idx, 6);
    async_reset("rst_emit");
    start_op(KEY_A1);
    collect(KEY_A1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
